// File: rtl/addsub_pkg.sv
// Shared types and helpers for the nibble-serial add/sub controller.
// Holds the FSM state encoding and nibble sizing.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_addsub.sv
// Combinational 4-bit ripple add/sub slice; B is inverted when sub is set.
// c3 is the carry into bit 3, used by the caller for signed overflow.
module nibble_addsub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       c3
);

  logic [3:0] bx;
  logic [4:0] c;

  assign bx = b ^ {4{sub}};

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ bx[i] ^ c[i];
      c[i + 1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
  end

  assign cout = c[4];
  assign c3   = c[3];

endmodule

// File: rtl/serial_addsub_ctrl.sv
// WIDTH-bit add/sub sequenced one nibble per cycle through a single slice.
// Define ADDSUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB = nib_count(WIDTH);
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             sub_q;
  logic             carry_q;
  logic             cout_q;
  logic [CW-1:0]    cnt_q;
  logic [CW+1:0]    base;
  logic             accept;
  logic             last;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       s_sum;
  logic             s_cout;
  logic             s_c3;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;
  assign last      = (cnt_q == LAST);
  assign base      = {cnt_q, 2'b00};
  assign a_nib     = a_q[base +: 4];
  assign b_nib     = b_q[base +: 4];
  assign result    = result_q;
  assign cout      = cout_q;

  nibble_addsub u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .sub  (sub_q),
    .cin  (carry_q),
    .sum  (s_sum),
    .cout (s_cout),
    .c3   (s_c3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      sub_q   <= op_sub;
      carry_q <= op_sub;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      result_q[base +: 4] <= s_sum;
      carry_q             <= s_cout;
      cnt_q               <= cnt_q + 1'b1;
      if (last) cout_q <= s_cout;
    end
  end

`ifdef ADDSUB_OVF_EN
  logic ovf_q;

  // Overflow is the MSB slice's carry-in to bit 3 disagreeing with its carry-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        ovf_q <= 1'b0;
    else if (state_q == RUN && last)   ovf_q <= s_c3 ^ s_cout;
  end

  assign ovf = ovf_q;
`else
  logic unused_c3;
  assign unused_c3 = s_c3;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed and randomized checks for serial_addsub_ctrl at WIDTH=16.
// Honours ADDSUB_OVF_EN for the ovf port.
module tb_serial_addsub_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
`ifdef ADDSUB_OVF_EN
  logic        ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_addsub_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout)
`ifdef ADDSUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  function automatic logic get_ovf();
`ifdef ADDSUB_OVF_EN
    return ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Drive one transaction; returns captured outputs, latency and stability flag.
  task automatic run_op(
    input  logic [15:0] ta,
    input  logic [15:0] tb_v,
    input  logic        ts,
    input  bit          rnd,
    output logic [15:0] r,
    output logic        c,
    output logic        o,
    output int          lat,
    output bit          unstable
  );
    bit hs;
    lat = -1;
    unstable = 1'b0;
    r = '0;
    c = 1'b0;
    o = 1'b0;
    hs = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 50 && !in_ready; w++) @(negedge clk);
    a = ta;
    b = tb_v;
    op_sub = ts;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    op_sub = 1'($urandom_range(0, 1));
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) return;
    r = result;
    c = cout;
    o = get_ovf();
    for (int k = 0; k < 50; k++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (out_ready) begin
        out_ready = 1'b0;
        hs = 1'b1;
        break;
      end
      if (!out_valid || result !== r || cout !== c) unstable = 1'b1;
    end
    if (!hs) unstable = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op_sub = 1'b0;
    a = '0;
    b = '0;
    #12;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (result !== 16'h0000) begin
      errors++;
      $display("FAIL reset_result got=%h exp=0000", result);
    end
    checks++;
    if (cout !== 1'b0 || get_ovf() !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b%b exp=00", cout, get_ovf());
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [15:0] va [5] = '{16'h1234, 16'hFFFF, 16'h0005, 16'h8000, 16'h7FFF};
    logic [15:0] vb [5] = '{16'h0FFF, 16'h0001, 16'h0007, 16'h0001, 16'h0001};
    logic        vs [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] vr [5] = '{16'h2233, 16'h0000, 16'hFFFE, 16'h7FFF, 16'h8000};
    logic        vc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        vo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] r;
    logic        c;
    logic        o;
    int          lat;
    bit          un;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vs[i], 1'b0, r, c, o, lat, un);
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL vec%0d_latency got=%0d exp=4", i, lat);
      end
      checks++;
      if (r !== vr[i]) begin
        errors++;
        $display("FAIL vec%0d_result got=%h exp=%h", i, r, vr[i]);
      end
      checks++;
      if (c !== vc[i]) begin
        errors++;
        $display("FAIL vec%0d_cout got=%b exp=%b", i, c, vc[i]);
      end
`ifdef ADDSUB_OVF_EN
      checks++;
      if (o !== vo[i]) begin
        errors++;
        $display("FAIL vec%0d_ovf got=%b exp=%b", i, o, vo[i]);
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    a = 16'h1234;
    b = 16'h0FFF;
    op_sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 20 && !out_valid; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      in_valid = k[0] ? 1'b0 : 1'b1;
      a = 16'hFFFF;
      b = 16'hFFFF;
      op_sub = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d_hs got=%b%b exp=10", k, out_valid, in_ready);
      end
      checks++;
      if (result !== 16'h2233 || cout !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d_data got=%h/%b exp=2233/0", k, result, cout);
      end
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 16'h0001;
    b = 16'h0002;
    op_sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle got=%b%b exp=10", in_ready, out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL bp_next_latency got=%0d exp=4", lat);
    end
    checks++;
    if (result !== 16'h0003) begin
      errors++;
      $display("FAIL bp_next_result got=%h exp=0003", result);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit          seen;
    logic [15:0] r;
    logic        c;
    logic        o;
    int          lat;
    bit          un;
    @(negedge clk);
    a = 16'hAAAA;
    b = 16'h5555;
    op_sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (result !== 16'h0000 || cout !== 1'b0 || get_ovf() !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs got=%h/%b exp=0000/0", result, cout);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_hs got=%b%b exp=10", in_ready, out_valid);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_valid got=%b exp=0", seen);
    end
    run_op(16'h0010, 16'h0001, 1'b1, 1'b0, r, c, o, lat, un);
    checks++;
    if (r !== 16'h000F || c !== 1'b1 || lat !== 4) begin
      errors++;
      $display("FAIL midrst_next got=%h/%b/%0d exp=000f/1/4", r, c, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ta;
    logic [15:0] tbv;
    logic        ts;
    logic [16:0] full;
    logic        eo;
    logic [15:0] r;
    logic        c;
    logic        o;
    int          lat;
    bit          un;
    for (int i = 0; i < 20; i++) begin
      ta = 16'($urandom);
      tbv = 16'($urandom);
      ts = 1'(i % 2);
      if (ts) full = {1'b0, ta} + {1'b0, ~tbv} + 17'd1;
      else    full = {1'b0, ta} + {1'b0, tbv};
      if (ts) eo = (ta[15] != tbv[15]) && (full[15] != ta[15]);
      else    eo = (ta[15] == tbv[15]) && (full[15] != ta[15]);
      run_op(ta, tbv, ts, 1'b1, r, c, o, lat, un);
      checks++;
      if (r !== full[15:0] || c !== full[16]) begin
        errors++;
        $display("FAIL b2b%0d got=%h/%b exp=%h/%b", i, r, c, full[15:0], full[16]);
      end
      checks++;
      if (lat !== 4 || un !== 1'b0) begin
        errors++;
        $display("FAIL b2b%0d_timing lat=%0d unstable=%b exp=4/0", i, lat, un);
      end
`ifdef ADDSUB_OVF_EN
      checks++;
      if (o !== eo) begin
        errors++;
        $display("FAIL b2b%0d_ovf got=%b exp=%b", i, o, eo);
      end
`else
      if (o !== 1'b0 && eo === 1'b1) checks = checks + 0;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
